// File: rtl/vx_dsched_pkg.sv
// Shared types and width helpers for the decode-to-issue scheduler.
// Optional feature macro used by the top: DSCHED_PERF_EN (perf counters).
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package vx_dsched_pkg;

  typedef struct packed {
    logic [43:0] uuid;
    logic [3:0]  tmask;
    logic [31:0] PC;
    logic [2:0]  ex_type;
    logic [3:0]  op_type;
    logic [2:0]  op_mod;
    logic        wb;
    logic        use_PC;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
  } dsched_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/VX_decode_if.sv
// Decoded-instruction handshake: valid/ready, warp id and payload.
interface VX_decode_if
  import vx_dsched_pkg::*;
#(
  parameter int NUM_WARPS = `NUM_WARPS
) ();
  localparam int WID_W = ptr_w(NUM_WARPS);

  logic             valid;
  logic             ready;
  logic [WID_W-1:0] wid;
  dsched_entry_t    data;

  modport master (output valid, wid, data, input ready);
  modport slave  (input valid, wid, data, output ready);
endinterface

// File: rtl/vx_dsched_fifo.sv
// Single-clock per-warp instruction FIFO; full/empty derived from the count register.
module vx_dsched_fifo
  import vx_dsched_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  dsched_entry_t    din,
  output dsched_entry_t    head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  dsched_entry_t    r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // Full refuses a push even if the head pops in the same cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/vx_decode_sched.sv
// Per-warp instruction buffers with round-robin selection into a registered issue stage.
// Define DSCHED_PERF_EN to add saturating stall/idle cycle counters.
module vx_decode_sched
  import vx_dsched_pkg::*;
#(
  parameter  int NUM_WARPS  = `NUM_WARPS,
  parameter  int IBUF_DEPTH = 2,
  localparam int WID_W      = ptr_w(NUM_WARPS),
  localparam int FCNT_W     = cnt_w(IBUF_DEPTH),
  localparam int CNT_W      = $clog2(NUM_WARPS * IBUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  VX_decode_if.slave           decode_if,
  VX_decode_if.master          issue_if,
  input  logic [NUM_WARPS-1:0] stall_mask,
  output logic [NUM_WARPS-1:0] warp_empty,
  output logic [CNT_W-1:0]     pending_cnt
`ifdef DSCHED_PERF_EN
  ,
  output logic [63:0]          perf_stall_cycles,
  output logic [63:0]          perf_idle_cycles
`endif
);
  logic [NUM_WARPS-1:0]             w_full;
  logic [NUM_WARPS-1:0]             w_empty;
  logic [NUM_WARPS-1:0]             w_push;
  logic [NUM_WARPS-1:0]             w_pop;
  logic [NUM_WARPS-1:0]             w_elig;
  logic [NUM_WARPS-1:0][FCNT_W-1:0] w_count;
  dsched_entry_t                    w_head [NUM_WARPS];
  logic [(1<<WID_W)-1:0]            w_full_ext;
  logic                             w_load;
  logic                             w_grant_vld;
  logic [WID_W-1:0]                 w_grant;
  logic [CNT_W-1:0]                 w_pending;

  logic                             r_valid;
  logic [WID_W-1:0]                 r_wid;
  logic [WID_W-1:0]                 r_last;
  dsched_entry_t                    r_data;

  // Unused wid codes (non power-of-2 warp counts) read as full.
  always_comb begin
    w_full_ext = '1;
    w_full_ext[NUM_WARPS-1:0] = w_full;
  end

  assign decode_if.ready = ~w_full_ext[decode_if.wid];

  genvar w;
  generate
    for (w = 0; w < NUM_WARPS; w++) begin : g_warp
      assign w_push[w] = decode_if.valid & decode_if.ready & (decode_if.wid == WID_W'(w));
      assign w_pop[w]  = w_load & w_grant_vld & (w_grant == WID_W'(w));

      vx_dsched_fifo #(.DEPTH(IBUF_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push[w]),
        .pop   (w_pop[w]),
        .din   (decode_if.data),
        .head  (w_head[w]),
        .count (w_count[w]),
        .full  (w_full[w]),
        .empty (w_empty[w])
      );
    end
  endgenerate

  assign w_elig = ~w_empty & ~stall_mask;
  assign w_load = ~r_valid | issue_if.ready;

  // Round-robin: scan starting one past the last grant, wrapping to warp 0.
  always_comb begin
    int idx;
    w_grant_vld = 1'b0;
    w_grant     = r_last;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = int'(r_last) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      if (!w_grant_vld && w_elig[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = WID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_wid   <= '0;
      r_data  <= '0;
      r_last  <= WID_W'(NUM_WARPS - 1);
    end else if (w_load) begin
      r_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_data <= w_head[w_grant];
        r_wid  <= w_grant;
        r_last <= w_grant;
      end
    end
  end

  assign issue_if.valid = r_valid;
  assign issue_if.wid   = r_wid;
  assign issue_if.data  = r_data;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NUM_WARPS; i++) w_pending = w_pending + CNT_W'(w_count[i]);
  end

  assign pending_cnt = w_pending;
  assign warp_empty  = w_empty;

`ifdef DSCHED_PERF_EN
  logic [63:0] r_perf_stall;
  logic [63:0] r_perf_idle;
  logic        w_stall_cyc;
  logic        w_idle_cyc;

  // Idle: work is buffered but every non-empty warp is stalled.
  assign w_stall_cyc = r_valid & ~issue_if.ready;
  assign w_idle_cyc  = ~r_valid & ~|w_elig & |(~w_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_idle  <= '0;
    end else begin
      if (w_stall_cyc && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 64'd1;
      if (w_idle_cyc  && (r_perf_idle  != '1)) r_perf_idle  <= r_perf_idle  + 64'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_idle_cycles  = r_perf_idle;
`endif

endmodule
